// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: shared types, defaults and helpers for the SPI command receiver
//   state_t  - receiver FSM encoding
//   clog2    - ceiling log2 usable in parameter and port declarations
//   frame_w  - command frame width in bits (opcode plus all address fields)
package spi_cmd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, WAIT_CS} state_t;

    localparam int DEF_ADDRW   = 8;
    localparam int DEF_OPCODEW = 2;

    function automatic int clog2(input int v);
        int r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    function automatic int frame_w(input int opw, input int aw, input int na);
        return opw + na * aw;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: show-ahead synchronous FIFO with occupancy output
//   clk, rst_n     - clock, asynchronous active-high reset
//   push, din      - write request and data; ignored when full unless a pop coincides
//   pop            - read request; ignored when empty
//   dout           - head entry, zero while empty
//   empty, full    - status flags
//   level          - number of stored entries
module cmd_fifo
    import spi_cmd_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
)(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            din,
    output logic [WIDTH-1:0]            dout,
    output logic                        empty,
    output logic                        full,
    output logic [clog2(DEPTH+1)-1:0]   level
);
    localparam int AW = clog2(DEPTH);
    localparam int LW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp, rp;
    logic             wr, rd;

    // pointers carry a wrap bit so full and empty are distinguishable
    assign empty = wp == rp;
    assign full  = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
    assign rd    = pop && !empty;
    assign wr    = push && (!full || rd);
    assign level = LW'(wp - rp);
    assign dout  = empty ? '0 : mem[rp[AW-1:0]];

    always_ff @(posedge clk or posedge rst_n)
        if (rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (rd) rp <= rp + 1'b1;
        end

    always_ff @(posedge clk)
        if (wr) mem[wp[AW-1:0]] <= din;

endmodule

// File: rtl/spi_cmd_rx.sv
// spi_cmd_rx: oversampling SPI command receiver with frame FIFO
//   clk, rst_n           - system clock, asynchronous active-high reset
//   spi_clk, mosi, cs_n  - SPI slave inputs, asynchronous to clk
//   ready_in             - consumer accepts the head frame
//   clr_err              - clears the sticky overflow flag
//   opcode, addr         - head frame fields, address field 0 in the MSBs
//   valid_out, level     - head frame valid, FIFO occupancy
//   frame_err            - one-cycle pulse on a truncated (or bad parity) frame
//   overflow             - sticky, a completed frame was dropped on a full FIFO
// Build option SPI_CMD_PARITY_EN: frames carry a trailing odd-parity bit.
module spi_cmd_rx
    import spi_cmd_pkg::*;
#(
    parameter int ADDRW      = DEF_ADDRW,
    parameter int OPCODEW    = DEF_OPCODEW,
    parameter int NADDR      = 2,
    parameter int DEPTH      = 4,
    parameter int SAMPLE_NEG = 0
)(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        spi_clk,
    input  logic                        mosi,
    input  logic                        cs_n,
    input  logic                        ready_in,
    input  logic                        clr_err,
    output logic [OPCODEW-1:0]          opcode,
    output logic [NADDR*ADDRW-1:0]      addr,
    output logic                        valid_out,
    output logic [clog2(DEPTH+1)-1:0]   level,
    output logic                        frame_err,
    output logic                        overflow
);
    localparam int FW = frame_w(OPCODEW, ADDRW, NADDR);
`ifdef SPI_CMD_PARITY_EN
    localparam int NB = FW + 1;
`else
    localparam int NB = FW;
`endif
    localparam int CW = clog2(NB + 1);

    logic [1:0]    sclk_s, cs_s, mosi_s, warm;
    logic          sclk_prev, seen_hi, cs, act, push, pop, full, empty, ok;
    logic [CW-1:0] cnt;
    logic [NB-1:0] sr;
    logic [FW-1:0] frame, head;
    state_t        state;

    // warm/seen_hi hold off frame start until a real (post-sync) cs_n high
    // is observed, so a frame interrupted by reset is never resumed mid-way
    always_ff @(posedge clk or posedge rst_n)
        if (rst_n) begin
            sclk_s    <= '0;
            cs_s      <= '1;
            mosi_s    <= '0;
            sclk_prev <= 1'b0;
            warm      <= '0;
            seen_hi   <= 1'b0;
        end else begin
            sclk_s    <= {sclk_s[0], spi_clk};
            cs_s      <= {cs_s[0], cs_n};
            mosi_s    <= {mosi_s[0], mosi};
            sclk_prev <= sclk_s[1];
            warm      <= {warm[0], 1'b1};
            if (warm[1] && cs_s[1]) seen_hi <= 1'b1;
        end

    assign cs  = cs_s[1];
    assign act = (SAMPLE_NEG != 0) ? (sclk_prev && !sclk_s[1]) : (!sclk_prev && sclk_s[1]);

`ifdef SPI_CMD_PARITY_EN
    assign frame = sr[NB-1:1];
    assign ok    = ^sr;
`else
    assign frame = sr;
    assign ok    = 1'b1;
`endif

    assign push = (state == COMMIT) && ok;
    assign pop  = valid_out && ready_in;

    always_ff @(posedge clk or posedge rst_n)
        if (rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            sr        <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (push && full && !pop) overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    sr  <= '0;
                    if (seen_hi && !cs) state <= SHIFT;
                end
                SHIFT:
                    if (cs) begin
                        frame_err <= cnt != '0;
                        state     <= IDLE;
                    end else if (act) begin
                        sr  <= {sr[NB-2:0], mosi_s[1]};
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(NB - 1)) state <= COMMIT;
                    end
                COMMIT: begin
`ifdef SPI_CMD_PARITY_EN
                    if (!ok) frame_err <= 1'b1;
`endif
                    state <= WAIT_CS;
                end
                default:
                    if (cs) state <= IDLE;
            endcase
        end

    cmd_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (frame),
        .dout  (head),
        .empty (empty),
        .full  (full),
        .level (level)
    );

    assign valid_out = !empty;
    assign opcode    = head[FW-1 -: OPCODEW];
    assign addr      = head[NADDR*ADDRW-1:0];

endmodule
